// File: rtl/seq_nand_scheduler.sv
// Serial N-input NAND: one shared 2-input nand cell evaluates y = ~&i over 2N-3 clocks.
// Optional macro SEQ_NAND_DONECNT_EN adds a saturating done_cnt transfer counter.
module seq_nand_scheduler #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] i,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
`ifdef SEQ_NAND_DONECNT_EN
   ,
   output logic [15:0]  done_cnt
`endif
);

   localparam int KW = $clog2(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   generate
      if (!(N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_n
         $error("seq_nand_scheduler: N must be 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t        state;
   logic [N-1:0]  opv;
   logic          acc;
   logic          t;
   logic [KW-1:0] k;
   logic          ph;

   logic cell_a;
   logic cell_b;
   logic cell_y;

   // The single shared cell: nand(acc, opv[k]) on phase 0, inverter on t for phase 1.
   always_comb begin
      cell_a = acc;
      cell_b = opv[k];
      if (ph) begin
         cell_a = t;
         cell_b = t;
      end
   end

   assign cell_y = ~(cell_a & cell_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         opv       <= '0;
         acc       <= 1'b0;
         t         <= 1'b0;
         k         <= '0;
         ph        <= 1'b0;
         y         <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  opv      <= i;
                  acc      <= i[0];
                  k        <= KW'(1);
                  ph       <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= EVAL;
               end
            end
            EVAL: begin
               if (!ph) begin
                  t <= cell_y;
                  if (k == K_LAST) begin
                     y         <= cell_y;
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     ph <= 1'b1;
                  end
               end else begin
                  // Inverting t restores the running AND for the next operand.
                  acc <= cell_y;
                  k   <= k + KW'(1);
                  ph  <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SEQ_NAND_DONECNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (out_valid && out_ready && (done_cnt != 16'hFFFF)) begin
         done_cnt <= done_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_nand_scheduler.sv
// Scoreboard bench for seq_nand_scheduler (N=4 main instance, plus N=2 and N=8 spot checks).
module tb_seq_nand_scheduler;

   localparam int N   = 4;
   localparam int LAT = 2 * N - 3;
   localparam int II  = 2 * N - 1;

   typedef struct {
      logic exp_y;
      int   acc_cyc;
   } item_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] i;
   logic         in_valid;
   logic         in_ready;
   logic         y;
   logic         out_valid;
   logic         out_ready;
   logic         busy;

   logic [1:0]   i2;
   logic         in_valid2, in_ready2, y2, out_valid2, busy2;
   logic [7:0]   i8;
   logic         in_valid8, in_ready8, y8, out_valid8, busy8;

`ifdef SEQ_NAND_DONECNT_EN
   logic [15:0]  done_cnt, done_cnt2, done_cnt8;
`endif

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    xfer_cnt = 0;
   bit    seen = 1'b0;
   item_t exp_q[$];

   seq_nand_scheduler #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .i(i), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef SEQ_NAND_DONECNT_EN
      , .done_cnt(done_cnt)
`endif
   );

   seq_nand_scheduler #(.N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .i(i2), .in_valid(in_valid2), .in_ready(in_ready2),
      .y(y2), .out_valid(out_valid2), .out_ready(1'b1), .busy(busy2)
`ifdef SEQ_NAND_DONECNT_EN
      , .done_cnt(done_cnt2)
`endif
   );

   seq_nand_scheduler #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .i(i8), .in_valid(in_valid8), .in_ready(in_ready8),
      .y(y8), .out_valid(out_valid8), .out_ready(1'b1), .busy(busy8)
`ifdef SEQ_NAND_DONECNT_EN
      , .done_cnt(done_cnt8)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drives one operand vector and holds in_valid until the DUT takes it; returns the accept edge.
   task automatic applyStimulus(input logic [N-1:0] v, output int acc_cyc);
      item_t it;
      acc_cyc  = -1;
      i        = v;
      in_valid = 1'b1;
      for (int w = 0; w < 100; w++) begin
         if (in_ready) begin
            acc_cyc    = cyc + 1;
            it.exp_y   = (v == {N{1'b1}}) ? 1'b0 : 1'b1;
            it.acc_cyc = acc_cyc;
            exp_q.push_back(it);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      if (acc_cyc < 0) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic waitOutValid(input string name);
      int w;
      for (w = 0; w < 100; w++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      if (w >= 100) checkOutput(name, 0, 1);
   endtask

   task automatic drain(input bit rnd);
      int w;
      for (w = 0; w < 300; w++) begin
         if (exp_q.size() == 0) break;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
      end
      if (w >= 300) checkOutput("drain_timeout", 0, 1);
      out_ready = 1'b1;
   endtask

   // Monitor: compares every presented result against the front of the scoreboard.
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         exp_q.delete();
         seen     = 1'b0;
         xfer_cnt = 0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_out_valid", 1, 0);
         end else begin
            if (!seen) begin
               checkOutput("latency", cyc - exp_q[0].acc_cyc, LAT);
               seen = 1'b1;
            end
            checkOutput("y", y, exp_q[0].exp_y);
            checkOutput("in_ready_while_done", in_ready, 0);
            checkOutput("busy_while_done", busy, 0);
            if (out_ready) begin
               void'(exp_q.pop_front());
               seen = 1'b0;
               xfer_cnt++;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a, prev, lat;
      logic [N-1:0] rv;

      rst_n = 1'b0; i = '0; in_valid = 1'b0; out_ready = 1'b1;
      i2 = '0; in_valid2 = 1'b0; i8 = '0; in_valid8 = 1'b0;

      @(negedge clk);
      checkOutput("reset_y", y, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1 checkOutput("in_ready_before_first_edge", in_ready, 0);
      @(negedge clk);
      checkOutput("in_ready_after_release", in_ready, 1);

      // All-ones: y=0, out_valid 5 cycles after accept, in_ready back one cycle later.
      applyStimulus(4'b1111, a);
      in_valid = 1'b0;
      checkOutput("busy_after_accept", busy, 1);
      waitOutValid("t1_out_valid_timeout");
      checkOutput("t1_out_valid_cycle", cyc - a, LAT);
      @(negedge clk);
      checkOutput("t1_in_ready_back", in_ready, 1);
      checkOutput("t1_out_valid_dropped", out_valid, 0);

      // Back-to-back sweep with in_valid held high.
      prev = -1;
      for (int v = 0; v < 16; v++) begin
         applyStimulus(N'(v), a);
         if (prev >= 0) checkOutput("sweep_accept_spacing", a - prev, II);
         prev = a;
      end
      in_valid = 1'b0;
      drain(1'b0);

      // Back-pressure with a competing request.
      out_ready = 1'b0;
      applyStimulus(4'b0111, a);
      i = 4'b1111;
      in_valid = 1'b1;
      waitOutValid("t3_out_valid_timeout");
      for (int c = 0; c < 4; c++) begin
         checkOutput("t3_y_stable", y, 1);
         checkOutput("t3_in_ready_low", in_ready, 0);
         checkOutput("t3_out_valid_held", out_valid, 1);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("t3_in_ready_after_xfer", in_ready, 1);

      // Reset in the middle of an evaluation.
      applyStimulus(4'b1111, a);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_y", y, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_out_valid", out_valid, 0);
      checkOutput("midreset_in_ready", in_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postreset_in_ready", in_ready, 1);
`ifdef SEQ_NAND_DONECNT_EN
      checkOutput("postreset_done_cnt", done_cnt, 0);
`endif
      applyStimulus(4'b1111, a);
      in_valid = 1'b0;
      drain(1'b0);
      applyStimulus(4'b1011, a);
      in_valid = 1'b0;
      drain(1'b0);
      applyStimulus(4'b1111, a);
      in_valid = 1'b0;
      drain(1'b0);
      @(negedge clk);
`ifdef SEQ_NAND_DONECNT_EN
      checkOutput("done_cnt_three", done_cnt, 3);
`endif

      // Randomized traffic with random back-pressure and operand churn during evaluation.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         rv = N'($urandom);
         if ($urandom_range(0, 3) == 0) rv = '1;
         applyStimulus(rv, a);
         in_valid = 1'b0;
         i = N'($urandom);
         drain(1'b1);
      end
      @(negedge clk);
`ifdef SEQ_NAND_DONECNT_EN
      checkOutput("done_cnt_model", done_cnt, (xfer_cnt > 65535) ? 65535 : xfer_cnt);
      force dut.done_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.done_cnt;
      applyStimulus(4'b0001, a);
      in_valid = 1'b0;
      drain(1'b0);
      @(negedge clk);
      checkOutput("done_cnt_saturate", done_cnt, 16'hFFFF);
`endif

      // N=2 instance: single operation.
      i2 = 2'b11;
      in_valid2 = 1'b1;
      #1 checkOutput("n2_in_ready", in_ready2, 1);
      @(negedge clk);
      in_valid2 = 1'b0;
      for (lat = 0; lat < 100 && !out_valid2; lat++) @(negedge clk);
      checkOutput("n2_latency", lat, 1);
      checkOutput("n2_y", y2, 0);

      // N=8 instance: 13 operations.
      for (int p = 0; p < 2; p++) begin
         i8 = (p == 0) ? 8'hFF : 8'hFE;
         in_valid8 = 1'b1;
         for (int w = 0; w < 20 && !in_ready8; w++) @(negedge clk);
         checkOutput("n8_in_ready", in_ready8, 1);
         @(negedge clk);
         in_valid8 = 1'b0;
         for (lat = 0; lat < 100 && !out_valid8; lat++) @(negedge clk);
         checkOutput("n8_latency", lat, 13);
         checkOutput("n8_y", y8, (p == 0) ? 0 : 1);
         @(negedge clk);
      end

      repeat (10) @(negedge clk);
      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
